gpio_bd_arbiter: RTL and testbench

GPIO_BD_ARBITER -- requirements
Module: gpio_bd_arbiter

---
 rtl/gpio_bd_pkg.sv | 17 +
 rtl/rr_arb2.sv | 33 +++
 rtl/gpio_bd_arbiter.sv | 124 ++++++++++++
 tb/tb_gpio_bd_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bd_pkg.sv
// gpio_bd_pkg
//   Shared definitions for the two-master PIO arbiter: the FSM state
//   encoding and the word offsets of the PIO register map.
package gpio_bd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDCAP = 2'd3
    } state_t;

    // PIO word offsets
    localparam int unsigned PIO_REG_DATA     = 0;
    localparam int unsigned PIO_REG_IRQ_MASK = 2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant. The grant is combinational from the request
//   vector; the last-granted pointer is registered and advances whenever a
//   grant is taken.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset
//     req[1:0]     : request per master
//     take         : the current grant is being consumed this cycle
//     gnt[1:0]     : one-hot grant (zero when nothing requests)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // 1 = m1 was granted last; reset to 1 so m0 wins the first contention
    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_q <= 1'b1;
        else if (take && (|req))
            last_q <= gnt[1];
    end

endmodule

// File: rtl/gpio_bd_arbiter.sv
// gpio_bd_arbiter
//   Shares one Avalon-style PIO slave between two requesters. An access is
//   arbitrated in IDLE, issued for one cycle in WR or RD, and a read spends
//   one extra RDCAP cycle capturing the PIO's registered readdata.
//   Ports:
//     clk, reset_n            : clock, synchronous active-low reset
//     mN_address/read/write/writedata : requester N command (held until accepted)
//     mN_waitrequest          : low only in the cycle the access is accepted
//     mN_readdata/readdatavalid : read return, valid for exactly one cycle
//     pio_*                   : drive of the shared PIO slave
//     proto_err               : sticky, a requester raised read and write together
module gpio_bd_arbiter
    import gpio_bd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [DATA_W-1:0] pio_writedata,
    input  logic [DATA_W-1:0] pio_readdata,
    output logic              proto_err
);

    state_t            state;
    logic              gnt_q;     // master owning the access in flight
    logic [1:0]        wait_q;
    logic [1:0]        rdv_q;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              take;
    logic              sel;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign req  = {m1_read | m1_write, m0_read | m0_write};
    assign take = (state == IDLE) && (|req);

    rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .take    (take),
        .gnt     (gnt)
    );

    // Write wins when a requester raises both strobes.
    assign sel      = gnt[1];
    assign sel_wr   = sel ? m1_write     : m0_write;
    assign sel_addr = sel ? m1_address   : m0_address;
    assign sel_data = sel ? m1_writedata : m0_writedata;

    assign m0_waitrequest   = wait_q[0];
    assign m1_waitrequest   = wait_q[1];
    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];

    // All outputs are registered: the IDLE grant cycle loads the PIO drive
    // and the accept strobe so they appear together in WR/RD.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            gnt_q          <= 1'b0;
            wait_q         <= 2'b11;
            rdv_q          <= 2'b00;
            m0_readdata    <= '0;
            m1_readdata    <= '0;
            pio_address    <= ADDR_W'(PIO_REG_DATA);
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            proto_err      <= 1'b0;
        end else begin
            wait_q         <= 2'b11;
            rdv_q          <= 2'b00;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            proto_err      <= proto_err | (m0_read & m0_write) | (m1_read & m1_write);

            case (state)
                IDLE: begin
                    if (take) begin
                        gnt_q          <= sel;
                        pio_address    <= sel_addr;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= ~sel_wr;
                        if (sel_wr) pio_writedata <= sel_data;
                        wait_q[sel]    <= 1'b0;
                        state          <= sel_wr ? WR : RD;
                    end
                end
                WR:    state <= IDLE;
                RD:    state <= RDCAP;
                RDCAP: begin
                    // PIO readdata is valid now, one cycle after the RD address
                    if (gnt_q) m1_readdata <= pio_readdata;
                    else       m0_readdata <= pio_readdata;
                    rdv_q[gnt_q] <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bd_arbiter.sv
module tb_gpio_bd_arbiter;
    import gpio_bd_pkg::*;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m0_address, m1_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] pio_address;
    logic          pio_chipselect, pio_write_n;
    logic [DW-1:0] pio_writedata, pio_readdata;
    logic          proto_err;

    int errors = 0;
    int checks = 0;

    // PIO slave stand-in: offset 0 reads the input port, offset 2 is the
    // IRQ mask register; readdata is registered from the address.
    logic [DW-1:0] in_port  = '0;
    logic [DW-1:0] pio_out  = '0;
    logic [DW-1:0] pio_mask = '0;

    logic done_m [2];

    gpio_bd_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .pio_address      (pio_address),
        .pio_chipselect   (pio_chipselect),
        .pio_write_n      (pio_write_n),
        .pio_writedata    (pio_writedata),
        .pio_readdata     (pio_readdata),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n) begin
            if (pio_address == 2'd0) pio_out <= pio_writedata;
            else if (pio_address == 2'd2) pio_mask <= pio_writedata;
        end
        case (pio_address)
            2'd0:    pio_readdata <= in_port;
            2'd2:    pio_readdata <= pio_mask;
            default: pio_readdata <= '0;
        endcase
    end

    task automatic set_req(input int m, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
        end
    endtask

    function automatic logic wait_of(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    // Called at a negedge; leaves the caller at a negedge with inputs idle.
    task automatic do_reset();
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Present one request, wait for its accept cycle and capture the PIO
    // drive seen there. Returns one negedge after the accept, request dropped.
    task automatic issue(input int m, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output logic cs, output logic wn,
                         output logic [AW-1:0] pa, output logic [DW-1:0] pd,
                         output logic other_wait);
        set_req(m, rd, wr, a, d);
        lat = -1; cs = 0; wn = 1; pa = '0; pd = '0; other_wait = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (wait_of(m) == 1'b0) begin
                lat = i; cs = pio_chipselect; wn = pio_write_n;
                pa = pio_address; pd = pio_writedata; other_wait = wait_of(1 - m);
                break;
            end
        end
        @(negedge clk);
        set_req(m, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_handshake: got wait/valid=%b expected 1100",
                     {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
        end
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address, proto_err} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_pio: got cs/wn/addr/perr=%b expected 01000",
                     {pio_chipselect, pio_write_n, pio_address, proto_err});
        end
        checks++;
        if (m0_readdata !== '0 || m1_readdata !== '0 || pio_writedata !== '0) begin
            errors++;
            $display("FAIL reset_data: got rd0=%h rd1=%h wd=%h expected all 0",
                     m0_readdata, m1_readdata, pio_writedata);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        int lat; logic cs, wn, ow; logic [AW-1:0] pa; logic [DW-1:0] pd;
        issue(0, 0, 1, 2'd0, 32'hA5A5_0001, lat, cs, wn, pa, pd, ow);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL write_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({cs, wn, pa, ow} !== 5'b10001 || pd !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL write_drive: got cs/wn/addr/m1wait=%b data=%h expected 10001 a5a50001",
                     {cs, wn, pa, ow}, pd);
        end
        checks++;
        if (pio_chipselect !== 1'b0 || pio_out !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL write_once: got cs=%b out=%h expected 0 a5a50001", pio_chipselect, pio_out);
        end
    endtask

    task automatic test_single_read();
        int lat; logic cs, wn, ow; logic [AW-1:0] pa; logic [DW-1:0] pd;
        in_port = 32'h0000_00FF;
        issue(1, 1, 0, 2'd0, '0, lat, cs, wn, pa, pd, ow);
        checks++;
        if (lat !== 1 || {cs, wn, pa} !== 4'b1100) begin
            errors++;
            $display("FAIL read_accept: got lat=%0d cs/wn/addr=%b expected 1 1100", lat, {cs, wn, pa});
        end
        checks++;
        if (m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL read_early_valid: got %b expected 0", m1_readdatavalid);
        end
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL read_return: got v1=%b v0=%b data=%h expected 1 0 000000ff",
                     m1_readdatavalid, m0_readdatavalid, m1_readdata);
        end
        @(negedge clk);
        in_port = 32'h1234_0000;
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL read_hold: got v1=%b data=%h expected 0 000000ff", m1_readdatavalid, m1_readdata);
        end
    endtask

    task automatic test_irq_mask();
        int lat; logic cs, wn, ow; logic [AW-1:0] pa; logic [DW-1:0] pd;
        issue(1, 0, 1, AW'(PIO_REG_IRQ_MASK), 32'h1, lat, cs, wn, pa, pd, ow);
        issue(0, 1, 0, AW'(PIO_REG_IRQ_MASK), '0, lat, cs, wn, pa, pd, ow);
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL irq_mask_read: got v0=%b data=%h expected 1 00000001", m0_readdatavalid, m0_readdata);
        end
    endtask

    task automatic test_proto_err();
        int lat; logic cs, wn, ow; logic [AW-1:0] pa; logic [DW-1:0] pd;
        issue(0, 1, 1, 2'd0, 32'h5A5A_0003, lat, cs, wn, pa, pd, ow);
        checks++;
        if ({cs, wn} !== 2'b10 || pd !== 32'h5A5A_0003) begin
            errors++;
            $display("FAIL proto_as_write: got cs/wn=%b data=%h expected 10 5a5a0003", {cs, wn}, pd);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err);
        end
        do_reset();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL proto_clear: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0; int last_t = 0; int t = 0;
        do_reset();
        set_req(0, 0, 1, 2'd0, 32'h0000_0100);
        set_req(1, 0, 1, 2'd2, 32'h0000_0200);
        while (n < 8 && t < 40) begin
            @(negedge clk); t++;
            if (!m0_waitrequest || !m1_waitrequest) begin
                checks++;
                if ({m1_waitrequest, m0_waitrequest} !== ((n % 2 == 0) ? 2'b10 : 2'b01) ||
                    (n > 0 && t - last_t != 2)) begin
                    errors++;
                    $display("FAIL alternate: accept %0d got waits=%b gap=%0d expected m%0d gap 2",
                             n, {m1_waitrequest, m0_waitrequest}, t - last_t, n % 2);
                end
                last_t = t; n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL alternate_count: got %0d accepts expected 8", n);
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_rdcap();
        do_reset();
        set_req(0, 1, 0, 2'd0, '0);
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0) begin
            errors++; $display("FAIL abort_accept: got m0 wait=%b expected 0", m0_waitrequest);
        end
        @(negedge clk);
        set_req(0, 0, 0, '0, '0);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest,
             pio_chipselect, pio_write_n} !== 6'b001101 || m0_readdata !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got v/w/cs/wn=%b rd0=%h expected 001101 0",
                     {m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest,
                      pio_chipselect, pio_write_n}, m0_readdata);
        end
        reset_n = 1'b1;
        set_req(0, 0, 1, 2'd0, 32'h11);
        set_req(1, 0, 1, 2'd0, 32'h22);
        @(negedge clk);
        checks++;
        if ({m1_waitrequest, m0_waitrequest} !== 2'b10 || m0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL abort_regrant: got waits=%b v0=%b expected 10 0",
                     {m1_waitrequest, m0_waitrequest}, m0_readdatavalid);
        end
        @(negedge clk);
        set_req(0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0) begin
            errors++; $display("FAIL abort_second: got m1 wait=%b expected 0", m1_waitrequest);
        end
        @(negedge clk);
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
    endtask

    task automatic drive_rand(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            logic wr = 1'($urandom_range(0, 1));
            logic [AW-1:0] a = AW'($urandom_range(0, 1) * 2);
            bit ok = 0;
            repeat (gap) @(negedge clk);
            set_req(m, ~wr, wr, a, $urandom);
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (wait_of(m) == 1'b0) begin ok = 1; break; end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL rand_timeout: m%0d request %0d not accepted within 50 cycles", m, i);
            end
            @(negedge clk);
            set_req(m, 0, 0, '0, '0);
        end
        done_m[m] = 1'b1;
    endtask

    typedef struct { int m; logic [DW-1:0] d; int due; } rd_exp_t;

    task automatic monitor_rand();
        rd_exp_t q[$];
        int cyc = 0;
        int last_w = 1;
        logic [DW-1:0] mdl_mask = pio_mask;
        while (!(done_m[0] && done_m[1] && q.size() == 0) && cyc < 3000) begin
            logic a0, a1, rq0, rq1, g_wr;
            logic [AW-1:0] g_a;
            logic [DW-1:0] g_d;
            logic [1:0] expv;
            int g;
            @(posedge clk); #1; cyc++;
            a0 = !m0_waitrequest; a1 = !m1_waitrequest;
            rq0 = m0_read | m0_write; rq1 = m1_read | m1_write;
            checks++;
            if ((a0 && a1) || pio_chipselect !== (a0 | a1)) begin
                errors++;
                $display("FAIL rand_accept: cycle %0d got a0=%b a1=%b cs=%b expected one accept with cs",
                         cyc, a0, a1, pio_chipselect);
            end
            if (a0 || a1) begin
                g    = a1 ? 1 : 0;
                g_wr = g ? m1_write : m0_write;
                g_a  = g ? m1_address : m0_address;
                g_d  = g ? m1_writedata : m0_writedata;
                checks++;
                if (pio_write_n !== !g_wr || pio_address !== g_a || (g_wr && pio_writedata !== g_d)) begin
                    errors++;
                    $display("FAIL rand_drive: m%0d got wn=%b addr=%0d wd=%h expected %b %0d %h",
                             g, pio_write_n, pio_address, pio_writedata, !g_wr, g_a, g_d);
                end
                if (rq0 && rq1) begin
                    checks++;
                    if (g == last_w) begin
                        errors++;
                        $display("FAIL rand_fair: got m%0d twice under contention expected m%0d", g, 1 - g);
                    end
                end
                last_w = g;
                if (g_wr) begin
                    if (g_a == 2'd2) mdl_mask = g_d;
                end else begin
                    q.push_back('{m: g, d: (g_a == 2'd0) ? in_port : mdl_mask, due: cyc + 2});
                end
            end
            expv = 2'b00;
            if (q.size() > 0 && q[0].due == cyc) expv[q[0].m] = 1'b1;
            checks++;
            if ({m1_readdatavalid, m0_readdatavalid} !== expv) begin
                errors++;
                $display("FAIL rand_valid: cycle %0d got %b expected %b", cyc,
                         {m1_readdatavalid, m0_readdatavalid}, expv);
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                if ((q[0].m ? m1_readdata : m0_readdata) !== q[0].d) begin
                    errors++;
                    $display("FAIL rand_rdata: m%0d got %h expected %h", q[0].m,
                             q[0].m ? m1_readdata : m0_readdata, q[0].d);
                end
                void'(q.pop_front());
            end
        end
        checks++;
        if (!(done_m[0] && done_m[1]) || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_end: got done=%b%b perr=%b expected 11 0", done_m[1], done_m[0], proto_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        in_port = $urandom;
        done_m[0] = 1'b0;
        done_m[1] = 1'b0;
        fork
            drive_rand(0, 40);
            drive_rand(1, 40);
            monitor_rand();
        join
    endtask

    initial begin
        reset_n = 1'b0;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
        test_reset();
        test_single_write();
        test_single_read();
        test_irq_mask();
        test_proto_err();
        test_back_to_back();
        test_reset_rdcap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
